// File: rtl/key_sync_filter.sv
// Multi-channel key conditioner: optional inversion, flop-chain synchroniser,
// consecutive-sample debounce, press/release pulses and optional auto-repeat.
module key_sync_filter #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned INVERT          = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned HOLD_CYCLES     = 50000,
    parameter int unsigned REPEAT_CYCLES   = 10000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out_level,
    output logic [WIDTH-1:0] out_press,
    output logic [WIDTH-1:0] out_release,
    output logic [WIDTH-1:0] out_rpt
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] ss;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= (INVERT != 0) ? ~in : in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign ss = sync_q[SYNC_STAGES-1];

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        logic [DB_W-1:0] cnt;
        logic            level;
        logic            press_q;
        logic            rel_q;
        logic            rpt_q;
        logic            rise;
        logic            fall;
        logic            rpt_due;

        always_comb begin
            rise = 1'b0;
            fall = 1'b0;
            if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                rise = ~level & ss[ch];
                fall = level & ~ss[ch];
            end
        end

        // A repeat landing on the release edge is dropped so only the release pulse fires.
        always_ff @(posedge sys_clk) begin
            if (rst) begin
                cnt     <= '0;
                level   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                if (ss[ch] == level) begin
                    cnt <= '0;
                end else if (rise || fall) begin
                    level <= ss[ch];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
                press_q <= rise | (rpt_due & ~fall);
                rel_q   <= fall;
                rpt_q   <= rpt_due & ~fall;
            end
        end

        if (REPEAT_EN != 0) begin : g_rpt
            typedef enum logic {PH_HOLD, PH_REPEAT} phase_t;
            phase_t          phase;
            logic [RC_W-1:0] rc;

            always_comb begin
                rpt_due = 1'b0;
                if (level) begin
                    if (phase == PH_HOLD) rpt_due = (rc >= RC_W'(HOLD_CYCLES - 1));
                    else                  rpt_due = (rc >= RC_W'(REPEAT_CYCLES - 1));
                end
            end

            always_ff @(posedge sys_clk) begin
                if (rst || !level) begin
                    rc    <= '0;
                    phase <= PH_HOLD;
                end else if (rpt_due) begin
                    rc    <= '0;
                    phase <= PH_REPEAT;
                end else begin
                    rc <= rc + RC_W'(1);
                end
            end
        end else begin : g_no_rpt
            assign rpt_due = 1'b0;
        end

        assign out_level[ch]   = level;
        assign out_press[ch]   = press_q;
        assign out_release[ch] = rel_q;
        assign out_rpt[ch]     = rpt_q;
    end

endmodule

// File: tb/tb_key_sync_filter.sv
// Directed self-checking bench for key_sync_filter with a short debounce and
// short repeat timing so every behaviour fits in a few hundred cycles.
module tb_key_sync_filter;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic [3:0] out_level;
    logic [3:0] out_press;
    logic [3:0] out_release;
    logic [3:0] out_rpt;

    int n_checks = 0;
    int n_fail   = 0;

    key_sync_filter #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .INVERT         (1),
        .REPEAT_EN      (1),
        .HOLD_CYCLES    (8),
        .REPEAT_CYCLES  (3)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .in         (in),
        .out_level  (out_level),
        .out_press  (out_press),
        .out_release(out_release),
        .out_rpt    (out_rpt)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e,
                           input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel, input logic [3:0] rpt);
        chk($sformatf("%s level e%0d", tag, e),   out_level,   lvl);
        chk($sformatf("%s press e%0d", tag, e),   out_press,   prs);
        chk($sformatf("%s release e%0d", tag, e), out_release, rel);
        chk($sformatf("%s rpt e%0d", tag, e),     out_rpt,     rpt);
    endtask

    initial begin
        logic [3:0] lvl, prs, rel, rpt;

        // Reset with all keys idle (active-low, so high)
        rst = 1'b1;
        in  = 4'hF;
        for (int e = 1; e <= 3; e++) tick();
        chk_all("reset", 3, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk_all("idle", e, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Clean press on channel 0: level and press at edge 6
        in = 4'hE;
        for (int e = 1; e <= 7; e++) begin
            tick();
            lvl = (e >= 6) ? 4'h1 : 4'h0;
            prs = (e == 6) ? 4'h1 : 4'h0;
            chk_all("press0", e, lvl, prs, 4'h0, 4'h0);
        end

        // Release channel 0 before its first repeat would be due
        in = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            lvl = (e < 6) ? 4'h1 : 4'h0;
            rel = (e == 6) ? 4'h1 : 4'h0;
            chk_all("release0", e, lvl, 4'h0, rel, 4'h0);
        end

        // Bounce on channel 1: 3 low, 1 high, 3 low, then high
        for (int e = 1; e <= 14; e++) begin
            in = (e <= 3 || (e >= 5 && e <= 7)) ? 4'hD : 4'hF;
            tick();
            chk_all("bounce1", e, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Auto-repeat on channel 2: press at 6, repeats at 14,17,...,41;
        // release captured at 39 falls at 44, where the due repeat is dropped
        in = 4'hB;
        for (int e = 1; e <= 50; e++) begin
            if (e == 39) in = 4'hF;
            tick();
            lvl = (e >= 6 && e < 44) ? 4'h4 : 4'h0;
            prs = (e == 6 || (e >= 14 && e < 44 && (e - 14) % 3 == 0)) ? 4'h4 : 4'h0;
            rel = (e == 44) ? 4'h4 : 4'h0;
            rpt = (e != 6) ? prs : 4'h0;
            chk_all("repeat2", e, lvl, prs, rel, rpt);
        end

        // All channels pressed together
        in = 4'h0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            lvl = (e >= 6) ? 4'hF : 4'h0;
            prs = (e == 6) ? 4'hF : 4'h0;
            chk_all("press_all", e, lvl, prs, 4'h0, 4'h0);
        end

        // Reset mid-hold: everything clears, no release pulse
        rst = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            chk_all("mid_reset", e, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        rst = 1'b0;

        // Keys still held: fresh press at edge 6 after reset release
        for (int e = 1; e <= 7; e++) begin
            tick();
            lvl = (e >= 6) ? 4'hF : 4'h0;
            prs = (e == 6) ? 4'hF : 4'h0;
            chk_all("repress_all", e, lvl, prs, 4'h0, 4'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
